// File: rtl/image_pipe_mc.sv
// image_pipe_mc: CH-channel pixel pipe (gain/offset, invert or bypass, mask, saturate) with output FIFO
// Ports: clk; rst (async, active-high)
//   upstream:   in_valid, in_data[CH*DATA_W], in_busy (hold pixel while 1)
//   downstream: out_valid, out_data[CH*DATA_W], out_busy (stall)
//   registers:  reg_cs, reg_we, reg_addr[ADDR_W], reg_wdata[32], reg_rdata[32] (registered read data)
// Optional feature: define IMAGE_PIPE_MC_SAT_CNT_EN to add the SAT_COUNT register at 0x6.
module image_pipe_mc #(
   parameter int CH         = 3,
   parameter int DATA_W     = 8,
   parameter int GAIN_W     = 8,
   parameter int GAIN_FRAC  = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_W     = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [CH*DATA_W-1:0] in_data,
   output logic                 in_busy,
   output logic                 out_valid,
   output logic [CH*DATA_W-1:0] out_data,
   input  logic                 out_busy,
   input  logic                 reg_cs,
   input  logic                 reg_we,
   input  logic [ADDR_W-1:0]    reg_addr,
   input  logic [31:0]          reg_wdata,
   output logic [31:0]          reg_rdata
);
   localparam int PW    = DATA_W + GAIN_W;
   localparam int SW    = PW + 2;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int PIX_W = CH * DATA_W;
   localparam logic [DATA_W-1:0] MAXV = '1;

   logic              en;
   logic [1:0]        mode;
   logic [GAIN_W-1:0] gain;
   logic [DATA_W:0]   offset;
   logic [CH-1:0]     mask;
   logic [31:0]       pix_count;
   logic              s1_v, s2_v;
   logic [PIX_W-1:0]  s1_x, s2_x, s2_res;
   logic [1:0]        s1_mode, s2_mode;
   logic [GAIN_W-1:0] s1_gain;
   logic [DATA_W:0]   s1_off, s2_off;
   logic [CH-1:0]     s1_mask, s2_mask;
   logic [CH*PW-1:0]  prod, s2_prod;
   logic [PIX_W-1:0]  mem [FIFO_DEPTH];
   logic [AW-1:0]     wptr, rptr;
   logic [AW:0]       count;
   logic              acc, rd, wr_reg, clr, m1;
   logic [31:0]       rd_mux, sat_rd;
   logic              unused_wdata;

   assign unused_wdata = ^reg_wdata;
   assign out_valid = count != '0;
   assign out_data  = out_valid ? mem[rptr] : '0;
   assign rd        = out_valid && !out_busy;
   // Every pixel in S1/S2 already owns a FIFO slot, so the pipeline never has to stall.
   assign in_busy   = !en || (32'(count) + 32'(s1_v) + 32'(s2_v) >= 32'(FIFO_DEPTH));
   assign acc       = in_valid && !in_busy;
   assign wr_reg    = reg_cs && reg_we;
   assign clr       = wr_reg && reg_addr == ADDR_W'(0) && reg_wdata[3];
   assign m1        = s2_mode == 2'd1;

`ifdef IMAGE_PIPE_MC_SAT_CNT_EN
   logic [CH-1:0] sat;
   logic [31:0]   sat_count;
   always_ff @(posedge clk or posedge rst)
      if (rst) sat_count <= '0;
      else     sat_count <= clr ? '0 : sat_count + 32'(s2_v && |sat);
   assign sat_rd = sat_count;
`else
   assign sat_rd = '0;
`endif

   for (genvar c = 0; c < CH; c++) begin : g_ch
      logic [DATA_W-1:0]    x;
      logic signed [SW-1:0] v;
      logic                 lo, hi;
      assign prod[c*PW +: PW] = PW'(s1_x[c*DATA_W +: DATA_W]) * PW'(s1_gain);
      assign x  = s2_x[c*DATA_W +: DATA_W];
      // Scaled product is non-negative; two guard bits let the signed offset push it below zero.
      assign v  = $signed({2'b00, s2_prod[c*PW +: PW] >> GAIN_FRAC})
                + $signed({{(SW-DATA_W-1){s2_off[DATA_W]}}, s2_off});
      assign lo = v[SW-1];
      assign hi = !lo && (v[SW-2:DATA_W] != '0);
      assign s2_res[c*DATA_W +: DATA_W] = !s2_mask[c] ? '0
                                        : m1 ? (lo ? '0 : hi ? MAXV : v[DATA_W-1:0])
                                        : s2_mode == 2'd2 ? MAXV - x : x;
`ifdef IMAGE_PIPE_MC_SAT_CNT_EN
      assign sat[c] = s2_mask[c] && m1 && (lo || hi);
`endif
   end

   always_comb begin
      rd_mux = '0;
      case (reg_addr)
         ADDR_W'(0): rd_mux = {29'b0, mode, en};
         ADDR_W'(1): rd_mux = 32'(gain);
         ADDR_W'(2): rd_mux = 32'(offset);
         ADDR_W'(3): rd_mux = 32'(mask);
         ADDR_W'(4): rd_mux = pix_count;
         ADDR_W'(5): rd_mux = {28'b0, !s1_v && !s2_v, in_busy,
                               count == (AW+1)'(FIFO_DEPTH), count == '0};
         ADDR_W'(6): rd_mux = sat_rd;
         default:    rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         en        <= 1'b0;
         mode      <= '0;
         gain      <= GAIN_W'(1 << GAIN_FRAC);
         offset    <= '0;
         mask      <= '1;
         pix_count <= '0;
         reg_rdata <= '0;
      end else begin
         if (wr_reg && reg_addr == ADDR_W'(0)) begin
            en   <= reg_wdata[0];
            mode <= reg_wdata[2:1];
         end
         if (wr_reg && reg_addr == ADDR_W'(1)) gain <= reg_wdata[GAIN_W-1:0];
         if (wr_reg && reg_addr == ADDR_W'(2)) offset <= reg_wdata[DATA_W:0];
         if (wr_reg && reg_addr == ADDR_W'(3)) mask <= reg_wdata[CH-1:0];
         pix_count <= clr ? '0 : pix_count + 32'(rd);
         if (reg_cs && !reg_we) reg_rdata <= rd_mux;
      end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         s1_v  <= 1'b0;
         s2_v  <= 1'b0;
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         s1_v  <= acc;
         s2_v  <= s1_v;
         wptr  <= wptr + AW'(s2_v);
         rptr  <= rptr + AW'(rd);
         count <= count + (AW+1)'(s2_v) - (AW+1)'(rd);
      end

   // Configuration is snapshotted with the pixel so later register writes cannot touch it.
   always_ff @(posedge clk) begin
      if (acc) begin
         s1_x    <= in_data;
         s1_mode <= mode;
         s1_gain <= gain;
         s1_off  <= offset;
         s1_mask <= mask;
      end
      s2_x    <= s1_x;
      s2_prod <= prod;
      s2_mode <= s1_mode;
      s2_off  <= s1_off;
      s2_mask <= s1_mask;
      if (s2_v) mem[wptr] <= s2_res;
   end
endmodule

// File: tb/tb_image_pipe_mc.sv
// tb_image_pipe_mc: scoreboard bench for image_pipe_mc with directed pixel vectors
module tb_image_pipe_mc;
`ifdef IMAGE_PIPE_MC_SAT_CNT_EN
   localparam int SAT_ON = 1;
`else
   localparam int SAT_ON = 0;
`endif
   logic        clk = 1'b0, rst = 1'b1;
   logic        in_valid, in_busy, out_valid, out_busy, reg_cs, reg_we;
   logic [23:0] in_data, out_data;
   logic [3:0]  reg_addr;
   logic [31:0] reg_wdata, reg_rdata;
   logic [23:0] exp_q[$];
   int          errors = 0, checks = 0, n_out = 0;

   always #5 clk = ~clk;

   image_pipe_mc dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_busy(in_busy),
      .out_valid(out_valid), .out_data(out_data), .out_busy(out_busy),
      .reg_cs(reg_cs), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_rdata(reg_rdata)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   always @(negedge clk)
      if (!rst && out_valid && !out_busy) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got 0x%0h, required no output", out_data);
         end else check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
         n_out++;
      end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
      reg_cs = 1; reg_we = 1; reg_addr = a; reg_wdata = d;
      tick();
      reg_cs = 0; reg_we = 0;
   endtask

   task automatic reg_read(input logic [3:0] a, input logic [31:0] req, input string name);
      reg_cs = 1; reg_we = 0; reg_addr = a;
      tick();
      reg_cs = 0;
      check(name, reg_rdata, req);
   endtask

   task automatic send(input logic [23:0] d, input logic [23:0] e);
      int n = 0;
      in_valid = 1; in_data = d;
      while (in_busy && n < 50) begin
         tick();
         n++;
      end
      if (in_busy) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_busy=1, required 0");
      end else begin
         exp_q.push_back(e);
         tick();
      end
      in_valid = 0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 50) begin
         tick();
         n++;
      end
      check("drain_outstanding", exp_q.size(), 0);
   endtask

   function automatic logic [23:0] pix(input int k);
      return {8'(k + 8'hA0), 8'(k + 8'h50), 8'(k)};
   endfunction

   initial begin
      int acc, base;
      in_valid = 0; in_data = '0; out_busy = 0;
      reg_cs = 0; reg_we = 0; reg_addr = '0; reg_wdata = '0;
      tick(); tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_in_busy", in_busy, 1);
      check("rst_reg_rdata", reg_rdata, 0);
      rst = 0;
      tick();
      reg_read(4'h1, 32'h10, "gain_reset");
      reg_read(4'h3, 32'h7, "mask_reset");
      reg_read(4'h0, 32'h0, "ctrl_reset");
      reg_read(4'h5, 32'hD, "status_reset");
      check("idle_in_busy", in_busy, 1);

      reg_write(4'h0, 32'h3);
      reg_write(4'h1, 32'h20);
      reg_write(4'h2, 32'h5);
      check("enabled_in_busy", in_busy, 0);
      send(24'hF08010, 24'hFFFF25);
      tick();
      check("latency_t2_out_valid", out_valid, 0);
      tick();
      check("latency_t3_out_valid", out_valid, 1);
      drain();
      reg_read(4'h4, 32'd1, "pix_count_1");
      reg_read(4'h6, 32'(SAT_ON), "sat_count_1");

      reg_write(4'h2, 32'h1E0);
      reg_write(4'h1, 32'h10);
      send(24'h204010, 24'h002000);
      reg_write(4'h1, 32'h40);
      drain();
      reg_read(4'h4, 32'd2, "pix_count_2");
      reg_read(4'h6, 32'(2 * SAT_ON), "sat_count_2");
      reg_write(4'h0, 32'hB);
      reg_read(4'h4, 32'd0, "pix_count_clr");
      reg_read(4'h6, 32'd0, "sat_count_clr");
      reg_read(4'h0, 32'h3, "ctrl_clr_selfclear");

      reg_write(4'h0, 32'h5);
      reg_write(4'h3, 32'h2);
      send(24'h563412, 24'h00CB00);
      reg_write(4'h1, 32'h30);
      drain();

      reg_write(4'h0, 32'h1);
      reg_write(4'h3, 32'h7);
      out_busy = 1;
      acc = 0;
      for (int i = 0; i < 16; i++) begin
         in_valid = 1;
         in_data = pix(acc);
         if (!in_busy) begin
            exp_q.push_back(pix(acc));
            acc++;
         end
         tick();
      end
      in_valid = 0;
      check("bp_accepted", 32'(acc), 32'd8);
      check("bp_in_busy", in_busy, 1);
      check("bp_out_valid", out_valid, 1);
      reg_read(4'h5, 32'hE, "status_full");
      base = n_out;
      out_busy = 0;
      repeat (8) tick();
      check("bp_backtoback_remaining", exp_q.size(), 0);
      check("bp_out_count", 32'(n_out - base), 32'd8);
      check("bp_out_valid_after", out_valid, 0);

      send(24'h0A0B0C, 24'h0A0B0C);
      reg_write(4'h0, 32'h0);
      check("disable_in_busy", in_busy, 1);
      drain();
      reg_write(4'h0, 32'h1);

      base = n_out;
      for (int i = 0; i < 5; i++) send(pix(8'h40 + i), pix(8'h40 + i));
      check("rst5_third_presented", out_valid, 1);
      check("rst5_two_out", 32'(n_out - base), 32'd2);
      rst = 1;
      exp_q.delete();
      tick();
      check("rst5_out_valid", out_valid, 0);
      check("rst5_in_busy", in_busy, 1);
      rst = 0;
      tick();
      reg_read(4'h4, 32'd0, "rst5_pix_count");
      reg_read(4'h0, 32'd0, "rst5_ctrl");
      reg_read(4'h5, 32'hD, "rst5_status");
      check("rst5_no_extra_out", 32'(n_out - base), 32'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end
endmodule

// File: doc/image_pipe_mc.md
Name: image_pipe_mc

Overview:
- Multi-channel successor to the single-pixel image pipe DUT.
- Processes CH-channel pixels through a fixed 2-stage arithmetic pipeline: gain, offset, invert or bypass, then per-channel mask and saturation.
- Uses valid/busy flow control on both streaming sides.
- Holds results in an output FIFO and is configured through the reg_cpu register port.
- Sits between the upstream pixel source (image_pipe agent) and a downstream consumer that can assert busy.

Parameters:
- CH, 3, number of colour channels per pixel.
- DATA_W, 8, bits per channel.
- GAIN_W, 8, unsigned gain width; fixed point with GAIN_FRAC fraction bits.
- GAIN_FRAC, 4, gain fraction bits (1.0 = 2^GAIN_FRAC).
- FIFO_DEPTH, 8, output FIFO entries; power of two, minimum 4.
- ADDR_W, 4, register address width.

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input pixel valid.
- in_data  in  CH*DATA_W  input pixel; channel 0 in the LSBs.
- in_busy  out  1  upstream must hold the pixel while this is 1.
- out_valid  out  1  output pixel valid.
- out_data  out  CH*DATA_W  output pixel.
- out_busy  in  1  downstream stall.
- reg_cs  in  1  register access strobe.
- reg_we  in  1  1 = write, 0 = read.
- reg_addr  in  ADDR_W  register address.
- reg_wdata  in  32  write data.
- reg_rdata  out  32  read data.

Behaviour:
- Reset: out_valid=0, out_data=0, in_busy=1, reg_rdata=0, FIFO empty, stage valids 0, counters 0.
- Register reset values: CTRL=0, GAIN=1<<GAIN_FRAC, OFFSET=0, CH_MASK=all ones.
- Input transfer: in_valid && !in_busy. Output transfer: out_valid && !out_busy.
- in_busy is combinational from registered state only: !CTRL.enable || (fifo_count + s1_valid + s2_valid >= FIFO_DEPTH). No overflow is possible.
- Config capture: mode, gain, offset and mask are captured at input acceptance and travel with the pixel. Register writes never affect pixels already in flight.
- Stage 1 (S1): product = x*gain, width DATA_W+GAIN_W.
- Stage 2 (S2): per mode, then clamp to [0, 2^DATA_W-1], then masked channels forced to 0.
  - mode 0 bypass: x.
  - mode 1 gain/offset: (product>>GAIN_FRAC) + sign-extended OFFSET.
  - mode 2 invert: (2^DATA_W-1) - x.
  - mode 3 reserved: behaves as bypass.
- S2 result is written to the FIFO at the end of S2.
- The pipeline never stalls. Pixels in S1/S2 always have a FIFO slot reserved by the in_busy rule.
- Latency: input accepted in cycle T → out_valid in T+3 when the FIFO is empty. Throughput 1 pixel/clk.
- FIFO is show-ahead: out_data is valid whenever out_valid=1. Simultaneous write and read in the same cycle is legal when full or empty.
- Order is strictly preserved.
- Registers (32-bit, unmapped bits read 0):
  - 0x0 CTRL RW: [0] enable, [2:1] mode, [3] clr_count (self-clearing, reads 0).
  - 0x1 GAIN RW.
  - 0x2 OFFSET RW: signed, DATA_W+1 bits.
  - 0x3 CH_MASK RW: [CH-1:0], 1 = channel passes.
  - 0x4 PIX_COUNT RO: output transfers, 32-bit, wraps to 0.
  - 0x5 STATUS RO: [0] fifo_empty, [1] fifo_full, [2] in_busy, [3] pipe_idle.
  - 0x6 SAT_COUNT (see optional feature).
  - Other addresses: read 0, writes ignored.
- Read timing: reg_rdata is registered and valid the cycle after reg_cs && !reg_we. It holds its value until the next read.
- Write timing: a write takes effect the next cycle.
- clr_count and an output transfer in the same cycle: the clear wins, and the count becomes 0.
- Clearing enable mid-stream: in_busy=1 immediately, the in-flight pixels and FIFO drain normally, and no data is lost.
- Reset mid-operation: all in-flight and FIFO data is discarded and registers return to their reset values.

Optional Feature:
- Macro: IMAGE_PIPE_MC_SAT_CNT_EN.
- Defined:
  - Register 0x6 SAT_COUNT RO, 32-bit wrapping.
  - Increments once per pixel written to the FIFO in which any unmasked channel clamped high or low.
  - Cleared by reset and by CTRL.clr_count.
- Undefined: no counter logic; reads of 0x6 return 0.

Test Plan:
- Reset, then read 0x1/0x3/0x0 → 0x10 / 0x7 / 0x0. in_busy=1, out_valid=0.
- enable=1, mode=1, GAIN=0x20, OFFSET=5, input {0x10,0x80,0xF0} (ch0..ch2) at cycle T → out_valid at T+3 with {0x25,0xFF,0xFF}. PIX_COUNT=1, SAT_COUNT=1 (macro on) or 0 (macro off).
- mode=1, GAIN=0x10, OFFSET=-0x20 (0x1E0), input {0x10,0x40,0x20} → {0x00,0x20,0x00}.
- out_busy=1 held, continuous in_valid, FIFO_DEPTH=8 → exactly 8 pixels accepted, then in_busy=1. Release out_busy → 8 pixels out in order, back-to-back, none lost or duplicated.
- mode=2, CH_MASK=0b010, input {0x12,0x34,0x56} → {0x00,0xCB,0x00}. A GAIN write while this pixel is in S1 does not alter it.
- Stream of 5 pixels, then assert rst during the 3rd output → out_valid=0 and FIFO empty next cycle. PIX_COUNT reads 0 and CTRL.enable=0 after release.
